frame_scheduler: RTL and testbench

Sequences the Tetris datapath: decides when the grid logic steps (gravity tick or player control) and when a new frame goes to the LED serializer. Sits between the top level and the grid/LED-controller pair. Issues one-cycle grid `enable` and LED `start` pulses, and waits for the serializer's `finished` handshake before allowing the next grid step, so a frame is never torn mid-transfer. Control edges and ticks that arrive while a frame is in flight are latched and coalesced.

---
 rtl/tetris_sched_pkg.sv | 24 ++
 rtl/ctrl_edge_latch.sv | 32 +++
 rtl/frame_scheduler.sv | 144 ++++++++++++++
 tb/tb_frame_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_sched_pkg.sv
// Shared types and constants for the Tetris frame scheduler.
package tetris_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EVT,
    STEP,
    SETTLE,
    REFRESH,
    WAIT_DONE
  } state_t;

  // {grid_ctrl1, grid_ctrl2} qualifier encodings
  localparam logic [1:0] CTRL_NONE = 2'b00;
  localparam logic [1:0] CTRL_1    = 2'b10;
  localparam logic [1:0] CTRL_2    = 2'b01;

  localparam int FRAME_CNT_W = 16;

  function automatic logic is_busy(input state_t s);
    return (s == STEP) || (s == SETTLE) || (s == REFRESH) || (s == WAIT_DONE);
  endfunction

endpackage

// File: rtl/ctrl_edge_latch.sv
// Rising-edge detector feeding a one-deep sticky pending flag.
module ctrl_edge_latch (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic d,
  input  logic clr,
  output logic pend
);

  logic prev_q, prev_d;
  logic pend_q, pend_d;

  // A new edge in the same cycle as a clear keeps the flag set.
  always_comb begin
    prev_d = d;
    pend_d = (en && d && !prev_q) || (pend_q && !clr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/frame_scheduler.sv
// Orders grid steps and LED frame sends so a frame is never torn mid-transfer.
module frame_scheduler
  import tetris_sched_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter int TIMEOUT  = 65_535
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   ctrl1_in,
  input  logic                   ctrl2_in,
  input  logic                   led_finished,
  output logic                   grid_enable,
  output logic                   grid_ctrl1,
  output logic                   grid_ctrl2,
  output logic                   led_start,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   timeout_err
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int WD_W   = $clog2(TIMEOUT);

  state_t                  state_q, state_d;
  logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    tick_pend_q, tick_pend_d;
  logic [1:0]              qual_q, qual_d;
  logic                    grid_enable_q, grid_enable_d;
  logic                    led_start_q, led_start_d;
  logic                    busy_q, busy_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [FRAME_CNT_W-1:0]  frame_count_q, frame_count_d;

  logic       active, in_step, tick_hit;
  logic [1:0] ctrl_in, ctrl_pend, ctrl_clr;

  assign active   = (state_q != IDLE);
  assign in_step  = (state_q == STEP);
  assign ctrl_in  = {ctrl1_in, ctrl2_in};
  // qual_q holds the serviced source during STEP, so it selects which flag to drop.
  assign ctrl_clr = {2{!active}} | ({2{in_step}} & qual_q);

  generate
    for (genvar i = 0; i < 2; i++) begin : g_ctrl
      ctrl_edge_latch u_latch (
        .clock (clock),
        .reset (reset),
        .en    (active),
        .d     (ctrl_in[i]),
        .clr   (ctrl_clr[i]),
        .pend  (ctrl_pend[i])
      );
    end
  endgenerate

  always_comb begin
    tick_hit      = active && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d    = (!active || tick_hit) ? '0 : tick_cnt_q + 1'b1;
    tick_pend_d   = tick_hit ||
                    (tick_pend_q && active && !(in_step && qual_q == CTRL_NONE));
    state_d       = state_q;
    wd_d          = wd_q;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;
    qual_d        = CTRL_NONE;

    case (state_q)
      IDLE:     if (start) state_d = WAIT_EVT;
      WAIT_EVT: begin
        if (!start) begin
          state_d = IDLE;
        end else if (ctrl_pend[1]) begin
          state_d = STEP;
          qual_d  = CTRL_1;
        end else if (ctrl_pend[0]) begin
          state_d = STEP;
          qual_d  = CTRL_2;
        end else if (tick_pend_q) begin
          state_d = STEP;
        end
      end
      STEP:     state_d = SETTLE;
      SETTLE:   state_d = REFRESH;
      REFRESH: begin
        state_d = WAIT_DONE;
        wd_d    = '0;
      end
      WAIT_DONE: begin
        if (led_finished) begin
          frame_count_d = frame_count_q + 1'b1;
          state_d       = WAIT_EVT;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = WAIT_EVT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default:  state_d = IDLE;
    endcase

    grid_enable_d = (state_d == STEP);
    led_start_d   = (state_d == REFRESH);
    busy_d        = is_busy(state_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      wd_q          <= '0;
      tick_pend_q   <= 1'b0;
      qual_q        <= CTRL_NONE;
      grid_enable_q <= 1'b0;
      led_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      wd_q          <= wd_d;
      tick_pend_q   <= tick_pend_d;
      qual_q        <= qual_d;
      grid_enable_q <= grid_enable_d;
      led_start_q   <= led_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign grid_enable = grid_enable_q;
  assign grid_ctrl1  = qual_q[1];
  assign grid_ctrl2  = qual_q[0];
  assign led_start   = led_start_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler with TICK_DIV=8, TIMEOUT=20.
module tb_frame_scheduler;

  logic        clock = 1'b0;
  logic        reset, start, ctrl1_in, ctrl2_in, led_finished;
  logic        grid_enable, grid_ctrl1, grid_ctrl2, led_start, busy, timeout_err;
  logic [15:0] frame_count;

  typedef struct {
    logic [1:0] q;
    int         cyc;
  } step_t;

  step_t sq[$];
  int    fq[$];
  int    n_pass = 0, n_total = 0;
  int    cyc = 0, fin_dly = 3, ge_cyc = -100, ls_cyc = -100;
  bit    mon_en = 1'b0;

  frame_scheduler #(.TICK_DIV(8), .TIMEOUT(20)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .ctrl1_in     (ctrl1_in),
    .ctrl2_in     (ctrl2_in),
    .led_finished (led_finished),
    .grid_enable  (grid_enable),
    .grid_ctrl1   (grid_ctrl1),
    .grid_ctrl2   (grid_ctrl2),
    .led_start    (led_start),
    .busy         (busy),
    .frame_count  (frame_count),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic nclk(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic push_step(input logic [1:0] q, input int c);
    step_t e;
    e.q   = q;
    e.cyc = c;
    sq.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    do begin
      nclk(1);
      n++;
    end while ((sq.size() != 0 || busy) && n < 300);
    chk("drain_idle", (sq.size() == 0 && !busy), 1);
    start = 1'b0;
    nclk(3);
  endtask

  // Monitor: pops expected steps / frame counts whenever the DUT presents one.
  initial begin
    step_t e;
    int    last_fc = 0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (grid_enable) begin
          ge_cyc = cyc;
          chk("step_queued", sq.size() > 0, 1);
          if (sq.size() > 0) begin
            e = sq.pop_front();
            chk("step_qual", {grid_ctrl1, grid_ctrl2}, e.q);
            chk("step_cycle", cyc, e.cyc);
          end
        end else begin
          chk("qual_idle", {grid_ctrl1, grid_ctrl2}, 0);
        end
        if (led_start) begin
          chk("ls_after_step", cyc - ge_cyc, 2);
          chk("ls_excl", grid_enable, 0);
          ls_cyc = cyc;
        end
        if (frame_count !== last_fc[15:0]) begin
          chk("fc_queued", fq.size() > 0, 1);
          if (fq.size() > 0) chk("frame_count", frame_count, fq.pop_front());
          last_fc = int'(frame_count);
        end
      end
    end
  end

  // Serializer model: one-cycle led_finished fin_dly cycles after led_start; 0 = never.
  initial begin
    int d;
    led_finished = 1'b0;
    forever begin
      @(negedge clock);
      if (led_start && fin_dly > 0) begin
        d = fin_dly;
        repeat (d - 1) @(negedge clock);
        led_finished = 1'b1;
        @(negedge clock);
        led_finished = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "bench stopped");
  end

  initial begin
    int b, n;
    reset = 1'b1; start = 1'b0; ctrl1_in = 1'b0; ctrl2_in = 1'b0;
    nclk(3);
    chk("rst_grid_enable", grid_enable, 0);
    chk("rst_led_start", led_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quals", {grid_ctrl1, grid_ctrl2}, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Gravity only: a tick step every 8 cycles
    fin_dly = 3;
    nclk(1); b = cyc; start = 1'b1;
    push_step(2'b00, b + 10); push_step(2'b00, b + 18); push_step(2'b00, b + 26);
    fq.push_back(1); fq.push_back(2); fq.push_back(3);
    drain();

    // ctrl1 rising in WAIT_EVT, then the regular tick
    nclk(1); b = cyc; start = 1'b1;
    nclk(2); ctrl1_in = 1'b1;
    push_step(2'b10, b + 4); push_step(2'b00, b + 10);
    fq.push_back(4); fq.push_back(5);
    nclk(4); ctrl1_in = 1'b0;
    drain();

    // Reset while waiting for the serializer with frame_count = 5
    fin_dly = 0;
    nclk(1); b = cyc; start = 1'b1;
    push_step(2'b00, b + 10);
    nclk(14);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_fc", frame_count, 5);
    fq.push_back(0);
    reset = 1'b1; start = 1'b0;
    nclk(1);
    chk("mid_rst_grid_enable", grid_enable, 0);
    chk("mid_rst_led_start", led_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fc", frame_count, 0);
    chk("mid_rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    nclk(2);

    // ctrl1 + ctrl2 together with a pending tick: 10, 01, 00
    fin_dly = 3;
    nclk(1); b = cyc; start = 1'b1;
    push_step(2'b10, b + 10); push_step(2'b01, b + 16); push_step(2'b00, b + 22);
    fq.push_back(1); fq.push_back(2); fq.push_back(3);
    nclk(8); ctrl1_in = 1'b1; ctrl2_in = 1'b1;
    nclk(3); ctrl1_in = 1'b0; ctrl2_in = 1'b0;
    drain();

    // ctrl2 toggles three times during a long WAIT_DONE: one ctrl2 step
    fin_dly = 8;
    nclk(1); b = cyc; start = 1'b1;
    push_step(2'b00, b + 10); push_step(2'b01, b + 21); push_step(2'b00, b + 27);
    fq.push_back(4); fq.push_back(5); fq.push_back(6);
    nclk(13);
    for (int i = 0; i < 6; i++) begin
      ctrl2_in = (i % 2 == 0);
      nclk(1);
    end
    fin_dly = 3;
    drain();

    // Serializer silent: watchdog expiry, then the next tick still steps
    fin_dly = 0;
    chk("timeout_pre", timeout_err, 0);
    nclk(1); b = cyc; start = 1'b1;
    push_step(2'b00, b + 10); push_step(2'b00, b + 34);
    fq.push_back(7);
    n = 0;
    while (!timeout_err && n < 60) begin
      nclk(1);
      n++;
    end
    chk("timeout_seen", timeout_err, 1);
    chk("timeout_lat", cyc - ls_cyc, 21);
    chk("timeout_fc", frame_count, 6);
    fin_dly = 3;
    drain();

    // start drops mid-frame: frame completes, then no more steps
    nclk(1); b = cyc; start = 1'b1;
    push_step(2'b00, b + 10);
    fq.push_back(8);
    nclk(11); start = 1'b0;
    nclk(25);
    chk("stop_busy", busy, 0);
    chk("stop_fc", frame_count, 8);
    chk("timeout_sticky", timeout_err, 1);

    chk("step_queue_empty", sq.size(), 0);
    chk("fc_queue_empty", fq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
